// File: rtl/rv32i_types.sv
// Shared types for the cache miss path: line/beat words and the burst adaptor states.
package rv32i_types;

    localparam int line_bits  = 32'd256;
    localparam int burst_bits = 32'd64;

    typedef logic [line_bits-1:0]  cacheline_t;
    typedef logic [burst_bits-1:0] burst_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DONE  = 3'd2,
        WR_BURST = 3'd3,
        WR_DONE  = 3'd4
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one cache-line read/write into a fixed-length memory burst,
// assembling beats on reads and serialising the line on writes.
module cacheline_adaptor
    import rv32i_types::*;
#(
    parameter int s_line  = line_bits,
    parameter int s_burst = burst_bits
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int               burst_len = s_line / s_burst;
    localparam int               cnt_w     = $clog2(burst_len);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(burst_len - 1);
    localparam logic [cnt_w-1:0] cnt_one   = cnt_w'(1);

    adaptor_state_t      state_r;
    logic [cnt_w-1:0]    cnt_r;
    logic [s_line-1:0]   buf_r;
    logic [s_line-1:0]   buf_fill_s;

    // Read demux: the line buffer with the incoming beat dropped into the current slot
    always_comb begin
        buf_fill_s = buf_r;
        buf_fill_s[int'(cnt_r)*s_burst +: s_burst] = burst_i;
    end

    // Write mux: current beat of the latched line, quiet outside a write burst
    always_comb begin
        if (state_r == WR_BURST) begin
            burst_o = buf_r[int'(cnt_r)*s_burst +: s_burst];
        end else begin
            burst_o = {s_burst{1'b0}};
        end
    end

    // Transaction FSM; address_o doubles as the latched request address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= {cnt_w{1'b0}};
            buf_r     <= {s_line{1'b0}};
            line_o    <= {s_line{1'b0}};
            address_o <= 32'd0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            resp_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Write-back takes priority so a dirty victim leaves before its refill
                    if (write_i) begin
                        buf_r     <= line_i;
                        address_o <= address_i;
                        cnt_r     <= {cnt_w{1'b0}};
                        write_o   <= 1'b1;
                        state_r   <= WR_BURST;
                    end else if (read_i) begin
                        address_o <= address_i;
                        cnt_r     <= {cnt_w{1'b0}};
                        read_o    <= 1'b1;
                        state_r   <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        buf_r <= buf_fill_s;
                        cnt_r <= cnt_r + cnt_one;
                        if (cnt_r == last_beat) begin
                            line_o  <= buf_fill_s;
                            read_o  <= 1'b0;
                            resp_o  <= 1'b1;
                            state_r <= RD_DONE;
                        end
                    end
                end
                RD_DONE: begin
                    state_r <= IDLE;
                end
                WR_BURST: begin
                    if (resp_i) begin
                        cnt_r <= cnt_r + cnt_one;
                        if (cnt_r == last_beat) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state_r <= WR_DONE;
                        end
                    end
                end
                WR_DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: a small memory model serves bursts while
// scoreboard queues hold the expected lines and write beats.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] line_i = 256'd0;
    logic [255:0] line_o;
    logic [31:0]  address_i = 32'd0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = 64'd0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    int total = 0;
    int bad = 0;

    logic [255:0] exp_lines[$];
    logic [63:0]  exp_wr[$];
    logic [63:0]  obs_wr[$];
    logic [63:0]  mem_q[$];

    int           rd_cyc, wr_cyc, resp_cnt, addr_bad, resp_at;
    logic [255:0] obs_line;
    bit           timed_out;
    logic [31:0]  exp_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers each burst cycle, records what the DUT shows, stops at resp_o
    task automatic serve(input bit stall, input bit keep_read, input bit scramble);
        bit phase;
        phase = 1'b0;
        rd_cyc = 0; wr_cyc = 0; resp_cnt = 0; addr_bad = 0; resp_at = 0;
        timed_out = 1'b1;
        obs_wr.delete();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (scramble && c == 0) begin
                address_i = 32'hDEAD_BEE0;
                line_i    = {4{64'hBAD0_BAD0_BAD0_BAD0}};
            end
            if (read_o)  rd_cyc++;
            if (write_o) wr_cyc++;
            if ((read_o || write_o) && address_o !== exp_addr) addr_bad++;
            if (write_o) obs_wr.push_back(burst_o);
            if (read_o || write_o) begin
                resp_i = stall ? phase : 1'b1;
                phase  = ~phase;
                if (resp_i && read_o) burst_i = (mem_q.size() > 0) ? mem_q.pop_front() : 64'd0;
            end else begin
                resp_i = 1'b0;
            end
            if (resp_o) begin
                resp_cnt++;
                resp_at  = c + 1;
                obs_line = line_o;
                write_i  = 1'b0;
                if (!keep_read) read_i = 1'b0;
                timed_out = 1'b0;
                break;
            end
        end
        resp_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        total++; if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: got rd=%b wr=%b resp=%b want 0 0 0", read_o, write_o, resp_o); end
        total++; if (address_o !== 32'd0) begin
            bad++; $display("FAIL reset_addr: got %h want 0", address_o); end
        total++; if (line_o !== 256'd0 || burst_o !== 64'd0) begin
            bad++; $display("FAIL reset_data: got line=%h burst=%h want 0", line_o, burst_o); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read_b2b();
        logic [255:0] b;
        b = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        for (int k = 0; k < 4; k++) mem_q.push_back(b[k*64 +: 64]);
        exp_lines.push_back(b);
        exp_addr = 32'h0000_1240; address_i = exp_addr; read_i = 1'b1;
        serve(1'b0, 1'b0, 1'b0);
        total++; if (timed_out) begin bad++; $display("FAIL rd_timeout: got no resp_o want resp_o"); end
        total++; if (rd_cyc !== 4) begin bad++; $display("FAIL rd_len: got %0d want 4", rd_cyc); end
        total++; if (addr_bad !== 0) begin bad++; $display("FAIL rd_addr: got %0d bad cycles want 0", addr_bad); end
        total++; if (resp_at !== 5) begin bad++; $display("FAIL rd_latency: got %0d want 5", resp_at); end
        total++; if (obs_line !== exp_lines[0]) begin
            bad++; $display("FAIL rd_line: got %h want %h", obs_line, exp_lines[0]); end
        void'(exp_lines.pop_front());
        tick();
        total++; if (resp_o !== 1'b0 || read_o !== 1'b0) begin
            bad++; $display("FAIL rd_pulse: got resp=%b rd=%b want 0 0", resp_o, read_o); end
    endtask

    task automatic test_write_stall(input bit scramble);
        logic [255:0] l;
        logic [7:0]   by;
        for (int k = 0; k < 4; k++) begin
            by = 8'hA0 + 8'(k);
            l[k*64 +: 64] = {8{by}};
            exp_wr.push_back({8{by}});
            exp_wr.push_back({8{by}});
        end
        exp_addr = 32'h0000_2000; address_i = exp_addr; line_i = l; write_i = 1'b1;
        serve(1'b1, 1'b0, scramble);
        total++; if (timed_out) begin bad++; $display("FAIL wr_timeout: got no resp_o want resp_o"); end
        total++; if (wr_cyc !== 8) begin bad++; $display("FAIL wr_len: got %0d want 8", wr_cyc); end
        total++; if (addr_bad !== 0) begin bad++; $display("FAIL wr_addr: got %0d bad cycles want 0", addr_bad); end
        total++; if (obs_wr.size() !== 8) begin bad++; $display("FAIL wr_beats: got %0d want 8", obs_wr.size()); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            logic [63:0] e, o;
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL wr_beat: got %h want %h", o, e); end
        end
        exp_wr.delete();
        tick();
        total++; if (resp_o !== 1'b0 || write_o !== 1'b0) begin
            bad++; $display("FAIL wr_pulse: got resp=%b wr=%b want 0 0", resp_o, write_o); end
    endtask

    task automatic test_simultaneous();
        logic [255:0] l, b;
        l = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
             64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        b = {64'h0BB3_1234_5678_9ABC, 64'h0BB2_0F0F_0F0F_0F0F,
             64'h0BB1_FFFF_0000_FFFF, 64'h0BB0_8000_0000_0001};
        for (int k = 0; k < 4; k++) begin
            exp_wr.push_back(l[k*64 +: 64]);
            mem_q.push_back(b[k*64 +: 64]);
        end
        exp_lines.push_back(b);
        exp_addr = 32'h0000_3000; address_i = exp_addr; line_i = l;
        read_i = 1'b1; write_i = 1'b1;
        serve(1'b0, 1'b1, 1'b0);
        total++; if (wr_cyc !== 4 || rd_cyc !== 0) begin
            bad++; $display("FAIL both_first: got wr=%0d rd=%0d want wr=4 rd=0", wr_cyc, rd_cyc); end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            logic [63:0] e, o;
            e = exp_wr.pop_front(); o = obs_wr.pop_front();
            total++; if (o !== e) begin bad++; $display("FAIL both_wbeat: got %h want %h", o, e); end
        end
        exp_wr.delete();
        serve(1'b0, 1'b0, 1'b0);
        total++; if (rd_cyc !== 4 || wr_cyc !== 0 || resp_cnt !== 1) begin
            bad++; $display("FAIL both_read: got rd=%0d wr=%0d resp=%0d want 4 0 1", rd_cyc, wr_cyc, resp_cnt); end
        total++; if (obs_line !== exp_lines[0]) begin
            bad++; $display("FAIL both_line: got %h want %h", obs_line, exp_lines[0]); end
        void'(exp_lines.pop_front());
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic [255:0] b;
        int spurious;
        exp_addr = 32'h0000_4000; address_i = exp_addr; read_i = 1'b1;
        tick();
        resp_i = 1'b1; burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        burst_i = 64'hBBBB_BBBB_BBBB_BBBB;
        tick();
        resp_i = 1'b0; read_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++; if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
            bad++; $display("FAIL rst_async_ctrl: got rd=%b wr=%b resp=%b want 0 0 0", read_o, write_o, resp_o); end
        total++; if (address_o !== 32'd0 || line_o !== 256'd0) begin
            bad++; $display("FAIL rst_async_data: got addr=%h line=%h want 0", address_o, line_o); end
        spurious = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (resp_o) spurious++; end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); if (resp_o || read_o) spurious++; end
        total++; if (spurious !== 0) begin bad++; $display("FAIL rst_spurious: got %0d want 0", spurious); end
        b = {64'hC3C3_C3C3_0000_0003, 64'hC2C2_C2C2_0000_0002,
             64'hC1C1_C1C1_0000_0001, 64'hC0C0_C0C0_0000_0000};
        for (int k = 0; k < 4; k++) mem_q.push_back(b[k*64 +: 64]);
        exp_lines.push_back(b);
        exp_addr = 32'h0000_5000; address_i = exp_addr; read_i = 1'b1;
        serve(1'b0, 1'b0, 1'b0);
        total++; if (resp_cnt !== 1 || resp_at !== 5) begin
            bad++; $display("FAIL rst_reread_lat: got resp=%0d at=%0d want 1 at 5", resp_cnt, resp_at); end
        total++; if (obs_line !== exp_lines[0]) begin
            bad++; $display("FAIL rst_reread_line: got %h want %h", obs_line, exp_lines[0]); end
        void'(exp_lines.pop_front());
        tick();
    endtask

    task automatic test_input_change();
        logic [255:0] b;
        test_write_stall(1'b1);
        b = {64'hE3E3_0000_1111_2222, 64'hE2E2_3333_4444_5555,
             64'hE1E1_6666_7777_8888, 64'hE0E0_9999_AAAA_BBBB};
        for (int k = 0; k < 4; k++) mem_q.push_back(b[k*64 +: 64]);
        exp_lines.push_back(b);
        exp_addr = 32'h0000_6000; address_i = exp_addr; read_i = 1'b1;
        serve(1'b1, 1'b0, 1'b1);
        total++; if (addr_bad !== 0 || rd_cyc !== 8) begin
            bad++; $display("FAIL chg_rd_addr: got bad=%0d rd=%0d want 0 8", addr_bad, rd_cyc); end
        total++; if (obs_line !== exp_lines[0]) begin
            bad++; $display("FAIL chg_rd_line: got %h want %h", obs_line, exp_lines[0]); end
        void'(exp_lines.pop_front());
        tick();
    endtask

    task automatic test_idle_noise();
        logic [255:0] b;
        read_i = 1'b0; write_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            tick();
            total++; if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
                bad++; $display("FAIL idle_noise: got rd=%b wr=%b resp=%b want 0 0 0", read_o, write_o, resp_o); end
        end
        resp_i = 1'b0;
        b = {64'h7777_0000_0000_0003, 64'h6666_0000_0000_0002,
             64'h5555_0000_0000_0001, 64'h4321_0000_0000_0000};
        for (int k = 0; k < 4; k++) mem_q.push_back(b[k*64 +: 64]);
        exp_lines.push_back(b);
        exp_addr = 32'h0000_7FE0; address_i = exp_addr; read_i = 1'b1;
        serve(1'b0, 1'b0, 1'b0);
        total++; if (resp_at !== 5 || obs_line !== exp_lines[0]) begin
            bad++; $display("FAIL idle_after_read: got at=%0d line=%h want 5 %h", resp_at, obs_line, exp_lines[0]); end
        void'(exp_lines.pop_front());
        tick();
    endtask

    initial begin
        test_reset();
        test_read_b2b();
        test_write_stall(1'b0);
        test_simultaneous();
        test_reset_mid_read();
        test_input_change();
        test_idle_noise();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
